// File: rtl/approx_mult_pkg.sv
// Shared types and elaboration helpers for the approximate multiplier pipeline.
// Mode encoding travels with every beat; the helpers size and sanity-check parameters.
package approx_mult_pkg;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    function automatic int default_acc_w(input int width);
        return 2 * width + 8;
    endfunction

    // Width of the low-column OR vector; a level of 0 still needs one (always-zero) bit.
    function automatic int low_w(input int l);
        return (l > 0) ? l : 1;
    endfunction

    function automatic bit params_legal(input int width, input int l, input int acc_w);
        return (width >= 4) && (width <= 32) &&
               (l >= 0) && (l <= 2 * width - 1) &&
               (acc_w >= 1);
    endfunction

endpackage

// File: rtl/approx_pp_compress.sv
// Combinational partial-product generation: columns below L collapse to one OR bit each,
// the remaining bits are kept as a row-per-multiplier-bit matrix for later reduction.
module approx_pp_compress
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int L     = 6
) (
    input  logic [WIDTH-1:0]            x,
    input  logic [WIDTH-1:0]            y,
    output logic [low_w(L)-1:0]         low_or,
    output logic [WIDTH-1:0][WIDTH-1:0] pp_hi
);

    // Row i holds x & y[i] at weight 2^i; bit j of that row lands in column i+j.
    always_comb begin
        low_or = '0;
        pp_hi  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (i + j < L) begin
                    low_or[i + j] = low_or[i + j] | (x[j] & y[i]);
                end else begin
                    pp_hi[i][j] = x[j] & y[i];
                end
            end
        end
    end

endmodule

// File: rtl/unsigned_approx_mult_pipe.sv
// Three-stage unsigned multiplier with a per-beat exact/approximate mode and
// saturating error statistics gathered on delivery of approximate beats.
module unsigned_approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int L     = 6,
    parameter int ACC_W = default_acc_w(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               mode,
    output logic [2*WIDTH-1:0] z,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               clr_stats,
    output logic [ACC_W-1:0]   err_acc,
    output logic [31:0]        approx_cnt
);

    localparam int PW    = 2 * WIDTH;
    localparam int LW    = low_w(L);
    localparam int SUM_W = ((ACC_W > PW) ? ACC_W : PW) + 1;
    localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_W{1'b1}});

    if (!params_legal(WIDTH, L, ACC_W)) begin : g_bad_params
        $error("unsigned_approx_mult_pipe: illegal WIDTH/L/ACC_W combination");
    end

    // Handshake: a beat moves in on a cycle with in_valid && in_ready and out on a cycle
    // with out_valid && out_ready. in_ready is low only when the output register is full
    // and not being drained; then every stage holds, so z/out_valid stay stable.
    logic advance;
    assign in_ready = !out_valid || out_ready;
    assign advance  = in_ready;

    // Stage 1 registers
    logic                            s1_valid;
    mode_e                           s1_mode;
    logic [LW-1:0]                   s1_low;
    logic [WIDTH-1:0][WIDTH-1:0]     s1_pp;
    logic [PW-1:0]                   s1_exact;

    // Stage 2 registers
    logic                            s2_valid;
    mode_e                           s2_mode;
    logic [LW-1:0]                   s2_low;
    logic [PW-1:0]                   s2_hi;
    logic [PW-1:0]                   s2_exact;

    // Stage 3 registers (z and out_valid are the ports themselves)
    mode_e                           s3_mode;
    logic [PW-1:0]                   s3_err;

    logic [LW-1:0]                   low_c;
    logic [WIDTH-1:0][WIDTH-1:0]     pp_c;
    logic [PW-1:0]                   exact_c;
    logic [PW-1:0]                   hi_c;
    logic [PW-1:0]                   approx_c;
    logic [PW-1:0]                   z_c;
    logic [PW-1:0]                   err_c;

    approx_pp_compress #(
        .WIDTH (WIDTH),
        .L     (L)
    ) u_compress (
        .x      (x),
        .y      (y),
        .low_or (low_c),
        .pp_hi  (pp_c)
    );

    assign exact_c = PW'(x) * PW'(y);

    // High-column reduction: sum the masked rows at their weights.
    always_comb begin
        hi_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            hi_c = hi_c + (PW'(s1_pp[i]) << i);
        end
    end

    // Every surviving high bit sits at column >= L, so the low L bits of s2_hi are zero
    // and adding the OR vector cannot carry; approx never exceeds exact.
    assign approx_c = s2_hi + PW'(s2_low);
    assign z_c      = (s2_mode == MODE_APPROX) ? approx_c : s2_exact;
    assign err_c    = s2_exact - approx_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mode   <= MODE_EXACT;
            s1_low    <= '0;
            s1_pp     <= '0;
            s1_exact  <= '0;
            s2_valid  <= 1'b0;
            s2_mode   <= MODE_EXACT;
            s2_low    <= '0;
            s2_hi     <= '0;
            s2_exact  <= '0;
            out_valid <= 1'b0;
            s3_mode   <= MODE_EXACT;
            s3_err    <= '0;
            z         <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_mode   <= mode_e'(mode);
            s1_low    <= low_c;
            s1_pp     <= pp_c;
            s1_exact  <= exact_c;
            s2_valid  <= s1_valid;
            s2_mode   <= s1_mode;
            s2_low    <= s1_low;
            s2_hi     <= hi_c;
            s2_exact  <= s1_exact;
            out_valid <= s2_valid;
            s3_mode   <= s2_mode;
            s3_err    <= err_c;
            z         <= z_c;
        end
    end

    logic             deliver_approx;
    logic [SUM_W-1:0] err_sum;

    assign deliver_approx = out_valid && out_ready && (s3_mode == MODE_APPROX);
    assign err_sum        = SUM_W'(err_acc) + SUM_W'(s3_err);

    // A clear in the same cycle as a delivery discards that beat's contribution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_acc    <= '0;
            approx_cnt <= '0;
        end else if (clr_stats) begin
            err_acc    <= '0;
            approx_cnt <= '0;
        end else if (deliver_approx) begin
            if (err_sum > ACC_MAX) begin
                err_acc <= '1;
            end else begin
                err_acc <= err_sum[ACC_W-1:0];
            end
            if (approx_cnt != '1) begin
                approx_cnt <= approx_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_unsigned_approx_mult_pipe.sv
// Directed bench for the approximate multiplier: scoreboard of expected products and
// statistics, plus a second instance with L=0 that must behave as an exact multiplier.
module tb_unsigned_approx_mult_pipe;

    localparam int W     = 8;
    localparam int PW    = 2 * W;
    localparam int LVL   = 6;
    localparam int ACC_W = 2 * W + 8;

    logic             clk = 1'b0;
    logic             rst_n;

    logic             in_valid, in_ready, mode, out_valid, out_ready, clr_stats;
    logic [W-1:0]     x, y;
    logic [PW-1:0]    z;
    logic [ACC_W-1:0] err_acc;
    logic [31:0]      approx_cnt;

    logic             in_valid0, in_ready0, out_valid0, out_ready0, clr_stats0;
    logic [W-1:0]     x0, y0;
    logic [PW-1:0]    z0;
    logic [ACC_W-1:0] err_acc0;
    logic [31:0]      approx_cnt0;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0]    exp_q[$];
    logic [PW-1:0]    err_q[$];
    logic             mode_q[$];
    logic [PW-1:0]    exp0_q[$];
    logic [ACC_W-1:0] exp_err;
    logic [31:0]      exp_cnt;
    logic             prev_stall;
    logic [PW-1:0]    prev_z;

    always #5 clk = ~clk;

    unsigned_approx_mult_pipe #(.WIDTH(W), .L(LVL), .ACC_W(ACC_W)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .mode       (mode),
        .z          (z),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .clr_stats  (clr_stats),
        .err_acc    (err_acc),
        .approx_cnt (approx_cnt)
    );

    unsigned_approx_mult_pipe #(.WIDTH(W), .L(0), .ACC_W(ACC_W)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid0),
        .in_ready   (in_ready0),
        .x          (x0),
        .y          (y0),
        .mode       (1'b1),
        .z          (z0),
        .out_valid  (out_valid0),
        .out_ready  (out_ready0),
        .clr_stats  (clr_stats0),
        .err_acc    (err_acc0),
        .approx_cnt (approx_cnt0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Column-count model: columns below lvl contribute one bit if any product bit is set.
    function automatic logic [PW-1:0] approx_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input int lvl);
        logic [31:0] total;
        int col_cnt;
        total = '0;
        for (int c = 0; c < 2 * W - 1; c++) begin
            col_cnt = 0;
            for (int i = 0; i < W; i++) begin
                int j;
                j = c - i;
                if (j >= 0 && j < W && a[i] && b[j]) col_cnt++;
            end
            if (c < lvl) begin
                if (col_cnt != 0) total += (32'd1 << c);
            end else begin
                total += (32'(col_cnt) << c);
            end
        end
        return total[PW-1:0];
    endfunction

    // Scoreboard and protocol monitor for the L=6 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            err_q.delete();
            mode_q.delete();
            exp_err    = '0;
            exp_cnt    = '0;
            prev_stall = 1'b0;
        end else begin
            logic [PW-1:0]    ez, ee;
            logic             em;
            logic [ACC_W:0]   s;
            check("in_ready_rule", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_z", z, prev_z);
            end
            check("err_acc", err_acc, exp_err);
            check("approx_cnt", approx_cnt, exp_cnt);
            if (out_valid && out_ready) begin
                check("output_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    ez = exp_q.pop_front();
                    ee = err_q.pop_front();
                    em = mode_q.pop_front();
                    check("z", z, ez);
                    if (em) begin
                        s = (ACC_W + 1)'(exp_err) + (ACC_W + 1)'(ee);
                        exp_err = s[ACC_W] ? '1 : s[ACC_W-1:0];
                        if (exp_cnt != '1) exp_cnt = exp_cnt + 1;
                    end
                end
            end
            if (clr_stats) begin
                exp_err = '0;
                exp_cnt = '0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(mode ? approx_model(x, y, LVL) : PW'(x) * PW'(y));
                err_q.push_back(PW'(x) * PW'(y) - approx_model(x, y, LVL));
                mode_q.push_back(mode);
            end
            prev_stall = out_valid && !out_ready;
            prev_z     = z;
        end
    end

    // Scoreboard for the L=0 instance: approximate mode must equal the true product.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp0_q.delete();
        end else begin
            if (out_valid0 && out_ready0) begin
                check("l0_output_expected", exp0_q.size() > 0, 1);
                if (exp0_q.size() > 0) check("l0_z", z0, exp0_q.pop_front());
            end
            if (in_valid0 && in_ready0) exp0_q.push_back(PW'(x0) * PW'(y0));
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        int n;
        logic acc;
        n = 0;
        in_valid = 1'b1;
        x = a;
        y = b;
        mode = m;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        check("send_accepted", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    int  cyc;
    bit  stream_done;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; x = '0; y = '0; mode = 1'b0;
        out_ready = 1'b1; clr_stats = 1'b0;
        in_valid0 = 1'b0; x0 = '0; y0 = '0; out_ready0 = 1'b1; clr_stats0 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_z", z, 0);
        check("rst_err_acc", err_acc, 0);
        check("rst_approx_cnt", approx_cnt, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // 255*255 approximate, with latency observed directly
        @(posedge clk); #1;
        send(8'd255, 8'd255, 1'b1);
        check("lat_edge1_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge2_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge3_valid", out_valid, 1);
        check("lat_edge3_z", z, 64767);
        drain();
        check("max_err_acc", err_acc, 258);
        check("max_approx_cnt", approx_cnt, 1);

        send(8'd3, 8'd3, 1'b1);
        drain();
        check("three_approx_err", err_acc, 260);
        send(8'd3, 8'd3, 1'b0);
        drain();
        check("three_exact_err", err_acc, 260);
        check("three_exact_cnt", approx_cnt, 2);

        send(8'd1, 8'd63, 1'b1);
        send(8'd0, 8'd200, 1'b1);
        send(8'd0, 8'd200, 1'b0);
        drain();
        check("zero_err_acc", err_acc, 260);
        check("zero_approx_cnt", approx_cnt, 4);

        // Back-to-back stream with out_ready toggling every 2 cycles
        stream_done = 1'b0;
        cyc = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                         1'($urandom_range(0, 1)));
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done && cyc < 400) begin
                    @(posedge clk); #1;
                    cyc++;
                    if (cyc % 2 == 0) out_ready = !out_ready;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight
        send(8'd10, 8'd20, 1'b1);
        send(8'd30, 8'd40, 1'b1);
        send(8'd50, 8'd60, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_z", z, 0);
        check("midrst_err_acc", err_acc, 0);
        check("midrst_approx_cnt", approx_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("postrst_out_valid", out_valid, 0);
        check("postrst_err_acc", err_acc, 0);
        check("postrst_approx_cnt", approx_cnt, 0);

        // Clear coinciding with an approximate delivery
        send(8'd3, 8'd3, 1'b1);
        drain();
        check("preclr_err_acc", err_acc, 2);
        check("preclr_approx_cnt", approx_cnt, 1);
        out_ready = 1'b0;
        send(8'd255, 8'd255, 1'b1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("clr_wait_valid", out_valid, 1);
        clr_stats = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        check("clr_err_acc", err_acc, 0);
        check("clr_approx_cnt", approx_cnt, 0);
        check("clr_delivered", exp_q.size(), 0);

        // L=0 instance: random approximate beats must be exact
        for (int k = 0; k < 20; k++) begin
            in_valid0 = 1'b1;
            x0 = (k == 0) ? 8'd255 : W'($urandom_range(0, 255));
            y0 = (k == 0) ? 8'd255 : W'($urandom_range(0, 255));
            @(posedge clk); #1;
        end
        in_valid0 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("l0_drain", exp0_q.size(), 0);
        check("l0_err_acc", err_acc0, 0);
        check("l0_approx_cnt", approx_cnt0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unsigned_approx_mult_pipe.md
UNSIGNED_APPROX_MULT_PIPE -- requirements
Module: unsigned_approx_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 4..32.
REQ-002 Parameter L, default 6: approximation level, i.e. the number of low product columns that are approximated; legal range 0..2*WIDTH-1.
REQ-003 Parameter ACC_W, default 2*WIDTH+8: width of the error accumulator.
REQ-004 clk  input  1: single clock, all state updates on the rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 in_valid  input  1: operand beat is offered.
REQ-007 in_ready  output  1: block accepts the beat this cycle.
REQ-008 x  input  WIDTH: multiplicand, unsigned.
REQ-009 y  input  WIDTH: multiplier, unsigned.
REQ-010 mode  input  1: per-beat mode; 0 = exact, 1 = approximate.
REQ-011 z  output  2*WIDTH: product.
REQ-012 out_valid  output  1: z is valid.
REQ-013 out_ready  input  1: downstream accepts z.
REQ-014 clr_stats  input  1: synchronous clear of the statistics.
REQ-015 err_acc  output  ACC_W: saturating sum of error distances.
REQ-016 approx_cnt  output  32: saturating count of completed approximate beats.

Function
REQ-017 Exact result SHALL be x*y.
REQ-018 Approximate result SHALL be the exact sum of all partial-product bits x[i]&y[j] with i+j>=L, plus, for each column c<L, (OR of all x[i]&y[j] with i+j=c) << c.
- No carry leaves any column c<L.
REQ-019 With L=0, approximate mode SHALL equal exact mode.
REQ-020 A beat is accepted when in_valid and in_ready are both 1; it is delivered when out_valid and out_ready are both 1.
REQ-021 Pipeline has 3 register stages:
- S1: partial products and low-column OR compression.
- S2: high-column reduction.
- S3: final add and output register.
REQ-022 Latency SHALL be 3 cycles from acceptance to out_valid, with no stalls.
REQ-023 in_ready = !S3_valid || out_ready; when in_ready is 0, all stages hold.
REQ-024 Throughput SHALL be 1 beat per cycle while out_ready is held at 1.
REQ-025 Beat order is preserved, and mode travels with its beat.
REQ-026 z and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 Bubbles (in_valid=0) propagate as invalid stages and do not stall the pipeline.
REQ-028 On delivery of an approximate beat:
- err_acc += (exact - approx), saturating at 2^ACC_W-1.
- approx_cnt += 1, saturating.
- exact beats leave both counters unchanged.
REQ-029 Error distance is always >= 0; the datapath carries the exact product alongside the approximate one for the error calculation.
REQ-030 clr_stats=1 zeroes err_acc and approx_cnt on the next edge. If a delivery occurs in the same cycle, the clear wins and that beat is not counted.

Reset
REQ-031 While rst_n=0:
- all stage valids are 0, out_valid=0, z=0;
- err_acc=0, approx_cnt=0;
- in_ready=1 once rst_n deasserts.
REQ-032 Reset mid-operation discards all in-flight beats; no partial result is ever presented.

Structure
REQ-033 Shared package approx_mult_pkg SHALL hold:
- the mode enum (MODE_EXACT=0, MODE_APPROX=1);
- a function returning the default accumulator width;
- a parameter-legality check used by elaboration assertions.
REQ-034 One combinational sub-module, approx_pp_compress (parameters WIDTH and L), SHALL produce the L-bit low-column OR vector and the high-column partial-product matrix; the top level owns all registers.

Verification (WIDTH=8, L=6)
REQ-035 x=255, y=255, mode=1 -> z=64767 after 3 cycles; err_acc=258; approx_cnt=1.
REQ-036 x=3, y=3, mode=1 -> z=7, err_acc += 2; the same operands with mode=0 -> z=9, counters unchanged.
REQ-037 x=1, y=63, mode=1 -> z=63, err_acc += 0; x=0, y=200 with either mode -> z=0.
REQ-038 Back-to-back stream of 10 beats, out_ready toggled every 2 cycles:
- in_ready follows REQ-023;
- outputs arrive in order, z stable during stalls;
- no beat lost or duplicated.
REQ-039 rst_n pulsed low with 3 beats in flight -> out_valid=0 and z=0 immediately; no stale beat emerges afterwards; counters are 0.
REQ-040 clr_stats asserted in the same cycle as an approximate delivery -> err_acc=0 and approx_cnt=0 next cycle; with L=0, random beats in mode 1 give z=x*y and err_acc remains 0.
